// File: rtl/legv8_fetch_pkg.sv
// Shared definitions for the LEGv8 fetch stage: state encoding, default widths,
// sequential PC step and reset constants (also used by the PC register and decode).
package legv8_fetch_pkg;

    localparam int unsigned FETCH_ADDR_W         = 32;
    localparam int unsigned FETCH_INSTR_W        = 32;
    localparam int unsigned FETCH_PC_STEP        = 4;
    localparam int unsigned FETCH_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam fetch_state_e                RST_STATE = S_IDLE;
    localparam logic [FETCH_ADDR_W-1:0]  RST_ADDR  = '0;
    localparam logic [FETCH_INSTR_W-1:0] RST_INSTR = '0;

endpackage

// File: rtl/legv8_fetch_hold_buffer.sv
// Single-entry skid register catching a fetched word that arrives while IF/ID is
// occupied and stalled. Flush has priority over load, load over drain.
module legv8_fetch_hold_buffer
    import legv8_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = FETCH_ADDR_W,
    parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_W'(RST_INSTR);
            pc_q    <= ADDR_W'(RST_ADDR);
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch stage: req/ack instruction fetch, next_pc generation, IF/ID register.
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module legv8_fetch_unit
    import legv8_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = FETCH_ADDR_W,
    parameter int unsigned INSTR_W        = FETCH_INSTR_W,
    parameter int unsigned PC_STEP        = FETCH_PC_STEP,
    parameter int unsigned TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  next_pc,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               imem_fault
);

    fetch_state_e       state_q;
    logic               kill_q;
    logic               imem_req_q;
    logic [ADDR_W-1:0]  imem_addr_q;
    logic               if_valid_q;
    logic [INSTR_W-1:0] if_instr_q;
    logic [ADDR_W-1:0]  if_pc_q;

    logic               accept_ack;
    logic               slot_busy;
    logic               issue;
    logic               hold_load;
    logic               hold_drain;
    logic               hold_flush;
    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr;
    logic [ADDR_W-1:0]  hold_pc;

    always_comb begin
        accept_ack = (state_q == S_REQ) && imem_ack && !kill_q && !branch_taken;
        slot_busy  = if_valid_q && stall;
        hold_load  = accept_ack && slot_busy;
        hold_drain = (state_q == S_HOLD) && !branch_taken && !stall;
        hold_flush = (state_q == S_HOLD) && branch_taken;

        // Every path that (re)launches a request loads imem_addr from next_pc.
        issue = 1'b0;
        case (state_q)
            S_IDLE:  issue = 1'b1;
            S_REQ:   issue = imem_ack && !hold_load;
            S_HOLD:  issue = branch_taken || !stall;
            default: issue = 1'b0;
        endcase

        if (branch_taken)
            next_pc = branch_target;
        else if (accept_ack)
            next_pc = pc + ADDR_W'(PC_STEP);
        else
            next_pc = pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RST_STATE;
            kill_q      <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= ADDR_W'(RST_ADDR);
            if_valid_q  <= 1'b0;
            if_instr_q  <= INSTR_W'(RST_INSTR);
            if_pc_q     <= ADDR_W'(RST_ADDR);
        end else begin
            if (issue) begin
                imem_req_q  <= 1'b1;
                imem_addr_q <= next_pc;
            end else if (hold_load) begin
                imem_req_q  <= 1'b0;
            end

            case (state_q)
                S_IDLE: state_q <= S_REQ;
                S_REQ: begin
                    // A redirect cannot withdraw the outstanding request; mark its data stale.
                    if (imem_ack)
                        kill_q <= 1'b0;
                    else if (branch_taken)
                        kill_q <= 1'b1;
                    if (hold_load)
                        state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (issue)
                        state_q <= S_REQ;
                end
                default: state_q <= S_IDLE;
            endcase

            if (branch_taken) begin
                if_valid_q <= 1'b0;
            end else if (accept_ack && !slot_busy) begin
                if_valid_q <= 1'b1;
                if_instr_q <= imem_rdata;
                if_pc_q    <= imem_addr_q;
            end else if (hold_drain && hold_valid) begin
                if_valid_q <= 1'b1;
                if_instr_q <= hold_instr;
                if_pc_q    <= hold_pc;
            end else if (!stall) begin
                if_valid_q <= 1'b0;
            end
        end
    end

    legv8_fetch_hold_buffer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .load_i  (hold_load),
        .drain_i (hold_drain),
        .flush_i (hold_flush),
        .instr_i (imem_rdata),
        .pc_i    (imem_addr_q),
        .valid_o (hold_valid),
        .instr_o (hold_instr),
        .pc_o    (hold_pc)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            if (issue)
                to_cnt_q <= '0;
            else if ((state_q == S_REQ) && !imem_ack && (to_cnt_q != TO_W'(TIMEOUT_CYCLES)))
                to_cnt_q <= to_cnt_q + 1'b1;
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES))
                fault_q <= 1'b1;
        end
    end

    assign imem_fault = fault_q;
`else
    assign imem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Directed bench for legv8_fetch_unit: cycle table plus async-reset and watchdog sequences.
module tb_legv8_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        imem_fault;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    // PC register: loads next_pc every clock.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else       pc <= next_pc;
    end

    assign imem_rdata = 32'h8B00_0000 + imem_addr;

    legv8_fetch_unit #(
        .ADDR_W         (32),
        .INSTR_W        (32),
        .PC_STEP        (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .next_pc       (next_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .imem_fault    (imem_fault)
    );

    typedef struct {
        bit          rst;
        bit          stall;
        bit          br;
        bit          ack;
        logic [31:0] tgt;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_v;
        logic [31:0] e_pc;
        logic [31:0] e_next;
    } vec_t;

    vec_t tab[$];

    task automatic add(input bit rst, input bit stl, input bit br, input bit ack,
                       input logic [31:0] tgt, input bit e_req, input logic [31:0] e_addr,
                       input bit e_v, input logic [31:0] e_pc, input logic [31:0] e_next);
        vec_t v;
        v.rst = rst; v.stall = stl; v.br = br; v.ack = ack; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_next = e_next;
        tab.push_back(v);
    endtask

    task automatic chk(input string name, input int unsigned row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        //   rst stl br ack tgt            req addr          v  if_pc         next_pc
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0);        // reset
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0);        // idle
        add(0, 0, 0, 1, 32'h0,          1, 32'h0,         0, 32'h0,        32'h4);        // zero-wait stream
        add(0, 0, 0, 1, 32'h0,          1, 32'h4,         1, 32'h0,        32'h8);
        add(0, 0, 0, 1, 32'h0,          1, 32'h8,         1, 32'h4,        32'hC);
        add(0, 0, 0, 1, 32'h0,          1, 32'hC,         1, 32'h8,        32'h10);
        add(0, 0, 0, 1, 32'h0,          1, 32'h10,        1, 32'hC,        32'h14);
        add(0, 1, 0, 1, 32'h0,          1, 32'h14,        1, 32'h10,       32'h18);       // ack into busy slot
        add(0, 1, 0, 0, 32'h0,          0, 32'h14,        1, 32'h10,       32'h18);       // S_HOLD
        add(0, 1, 0, 0, 32'h0,          0, 32'h14,        1, 32'h10,       32'h18);
        add(0, 1, 0, 0, 32'h0,          0, 32'h14,        1, 32'h10,       32'h18);
        add(0, 0, 0, 0, 32'h0,          0, 32'h14,        1, 32'h10,       32'h18);       // stall release
        add(0, 0, 0, 1, 32'h0,          1, 32'h18,        1, 32'h14,       32'h1C);
        add(0, 0, 0, 0, 32'h0,          1, 32'h1C,        1, 32'h18,       32'h1C);
        add(0, 0, 0, 1, 32'h0,          1, 32'h1C,        0, 32'h18,       32'h20);
        add(0, 0, 1, 1, 32'h40,         1, 32'h20,        1, 32'h1C,       32'h40);       // branch with ack
        add(0, 0, 0, 0, 32'h0,          1, 32'h40,        0, 32'h1C,       32'h40);
        add(0, 0, 1, 0, 32'h200,        1, 32'h40,        0, 32'h1C,       32'h200);      // branch while pending
        add(0, 0, 0, 0, 32'h0,          1, 32'h40,        0, 32'h1C,       32'h200);
        add(0, 0, 0, 1, 32'h0,          1, 32'h40,        0, 32'h1C,       32'h200);      // killed data
        add(0, 0, 0, 1, 32'h0,          1, 32'h200,       0, 32'h1C,       32'h204);
        add(0, 1, 0, 1, 32'h0,          1, 32'h204,       1, 32'h200,      32'h208);      // into S_HOLD
        add(0, 1, 1, 0, 32'h300,        0, 32'h204,       1, 32'h200,      32'h300);      // branch in S_HOLD
        add(0, 0, 0, 1, 32'h0,          1, 32'h300,       0, 32'h200,      32'h304);
        add(0, 0, 0, 0, 32'h0,          1, 32'h304,       1, 32'h300,      32'h304);
        add(0, 0, 0, 0, 32'h0,          1, 32'h304,       0, 32'h300,      32'h304);
        add(1, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0);        // reset again
        add(0, 0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'h0);        // 3-cycle latency
        add(0, 0, 0, 0, 32'h0,          1, 32'h0,         0, 32'h0,        32'h0);
        add(0, 0, 0, 1, 32'h0,          1, 32'h0,         0, 32'h0,        32'h4);
        add(0, 0, 0, 0, 32'h0,          1, 32'h4,         1, 32'h0,        32'h4);
        add(0, 0, 1, 0, 32'hFFFF_FFFC,  1, 32'h4,         0, 32'h0,        32'hFFFF_FFFC); // wrap setup
        add(0, 0, 0, 1, 32'h0,          1, 32'h4,         0, 32'h0,        32'hFFFF_FFFC);
        add(0, 0, 0, 1, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0);
        add(0, 0, 0, 0, 32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);

        foreach (tab[i]) begin
            @(posedge clk);
            #1;
            reset         = tab[i].rst;
            stall         = tab[i].stall;
            branch_taken  = tab[i].br;
            branch_target = tab[i].tgt;
            imem_ack      = tab[i].ack;
            @(negedge clk);
            chk("imem_req",  i, {31'b0, imem_req}, {31'b0, tab[i].e_req});
            chk("imem_addr", i, imem_addr, tab[i].e_addr);
            chk("if_valid",  i, {31'b0, if_valid}, {31'b0, tab[i].e_v});
            chk("if_pc",     i, if_pc, tab[i].e_pc);
            chk("next_pc",   i, next_pc, tab[i].e_next);
            if (tab[i].e_v)
                chk("if_instr", i, if_instr, 32'h8B00_0000 + tab[i].e_pc);
        end

        // Late ack while idle after reset is ignored; then async reset between edges.
        @(posedge clk); #1;
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ack = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ack_valid", 100, {31'b0, if_valid}, 32'h0);
        chk("idle_ack_req",   100, {31'b0, imem_req}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_idle_req",   101, {31'b0, imem_req}, 32'h1);
        chk("post_idle_addr",  101, imem_addr, 32'h0);
        chk("post_idle_valid", 101, {31'b0, if_valid}, 32'h0);
        @(posedge clk); #1;
        imem_ack = 1'b0; stall = 1'b1;
        @(negedge clk);
        chk("pre_rst_addr",  102, imem_addr, 32'h4);
        chk("pre_rst_instr", 102, if_instr, 32'h8B00_0000);
        #1 reset = 1'b1;
        #1;
        chk("async_req",   103, {31'b0, imem_req}, 32'h0);
        chk("async_addr",  103, imem_addr, 32'h0);
        chk("async_valid", 103, {31'b0, if_valid}, 32'h0);
        chk("async_instr", 103, if_instr, 32'h0);

        // Watchdog: request left unanswered for well over 64 cycles.
        @(posedge clk); #1;
        reset = 1'b0; stall = 1'b0;
        for (int unsigned k = 0; k < 12; k++) @(posedge clk);
        #1;
        chk("fault_early", 104, {31'b0, imem_fault}, 32'h0);
        for (int unsigned k = 0; k < 60; k++) @(posedge clk);
        #1;
        chk("fault_set", 105, {31'b0, imem_fault}, {31'b0, TO_EN});
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(posedge clk); #1;
        chk("fault_sticky", 106, {31'b0, imem_fault}, {31'b0, TO_EN});
        chk("fault_after_ack_valid", 106, {31'b0, if_valid}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/legv8_fetch_unit.md
Name: legv8_fetch_unit

Overview:
- Fetch stage that sits directly downstream of the 32-bit program counter register.
- Consumes the current PC and issues a request/acknowledge fetch to instruction memory.
- Writes the fetched word into the IF/ID pipeline register.
- Computes next_pc (PC+4, branch target, or hold) and drives it back into the PC register's input.
- Handles variable memory latency, decode stalls and branch redirects, including discarding a fetch that is in flight.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width
- INSTR_W, 32, instruction word width
- PC_STEP, 4, byte increment per sequential fetch
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pc  in  ADDR_W  current value of the PC register
- next_pc  out  ADDR_W  combinational; drives the PC register's load input, which loads every clk
- branch_taken  in  1  redirect request from EX; also flushes the fetch stage
- branch_target  in  ADDR_W  redirect address, valid while branch_taken=1
- stall  in  1  decode cannot accept; IF/ID contents must be held
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  single-cycle completion; imem_rdata is valid in the same cycle
- imem_rdata  in  INSTR_W  fetched instruction
- if_valid  out  1  IF/ID register holds a live instruction
- if_instr  out  INSTR_W  IF/ID instruction
- if_pc  out  ADDR_W  address the IF/ID instruction was fetched from
- imem_fault  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state=S_IDLE, kill=0.
  - imem_req=0, imem_addr=0.
  - if_valid=0, if_instr=0, if_pc=0.
  - hold_instr=0, hold_pc=0, imem_fault=0.
- next_pc (combinational, evaluated in priority order):
  - branch_taken: branch_target.
  - Else, an accepted ack (S_REQ, imem_ack=1, kill=0): pc+PC_STEP, modulo 2^ADDR_W; wraps from 0xFFFFFFFC to 0.
  - Otherwise: pc.
- "Issue" means imem_req<=1 and imem_addr<=next_pc.
- S_IDLE: issue, then go to S_REQ. This is the first cycle after reset is released, so request address 0 goes out on the second edge.
- S_REQ with no ack:
  - Hold imem_req and imem_addr.
  - If branch_taken, set kill<=1. The outstanding request cannot be withdrawn.
- S_REQ with ack while kill or branch_taken is set:
  - Drop imem_rdata.
  - kill<=0.
  - Issue at next_pc (the target if branch_taken, else pc, which already holds the earlier target).
  - Stay in S_REQ.
- S_REQ with an accepted ack and a free slot (if_valid=0 or stall=0):
  - if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1.
  - Issue at pc+PC_STEP; back-to-back requests are allowed.
  - Stay in S_REQ.
- S_REQ with an accepted ack and a busy slot (if_valid=1 and stall=1):
  - hold_instr<=imem_rdata, hold_pc<=imem_addr.
  - imem_req<=0.
  - Go to S_HOLD. PC still advances by PC_STEP.
- S_HOLD:
  - stall=0: move hold to IF/ID (if_valid<=1), issue at pc, go to S_REQ.
  - branch_taken: discard hold, issue at branch_target, go to S_REQ. This has priority over stall.
- IF/ID register:
  - branch_taken forces if_valid<=0 in every state, with priority over capture and stall.
  - stall=0 with no capture gives if_valid<=0.
  - stall=1 holds if_valid, if_instr and if_pc unchanged.
- Reset asserted mid-request: all state clears immediately. Any late imem_ack while in S_IDLE is ignored.
- Fetch-to-decode latency: one cycle after imem_ack.
- Steady-state throughput: one instruction per cycle with a zero-wait memory, where ack arrives in the cycle after issue.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on every issue and increments each cycle in S_REQ without ack.
  - When it reaches TIMEOUT_CYCLES, imem_fault<=1, sticky until reset.
  - The FSM is unaffected.
- Undefined: no counter is built; imem_fault is tied to 0. The port exists in both builds.

Decomposition:
- Shared package legv8_fetch_pkg:
  - state encoding S_IDLE/S_REQ/S_HOLD
  - PC_STEP
  - reset constants
  - ADDR_W/INSTR_W defaults, which the PC register and decode also use
- One sub-module, legv8_fetch_hold_buffer: the hold register plus its valid bit, with load, drain and flush ports.
- The FSM, next_pc logic and IF/ID register stay in the top module.

Test Plan:
- Reset release, zero-wait memory returning 0x8B000000+addr:
  - imem_addr goes 0,4,8,C on consecutive cycles.
  - if_pc follows one cycle later, if_valid=1 continuously.
  - next_pc equals pc+4 each cycle.
- 3-cycle ack latency: imem_addr=0 held for 3 cycles; next_pc=pc until ack; if_instr captured one cycle after ack.
- stall high for 4 cycles while IF/ID holds pc 0x10 and the ack for 0x14 arrives:
  - FSM enters S_HOLD with imem_req=0.
  - On stall release, if_pc=0x14, then a request for 0x18 is issued.
- branch_taken pulse with target 0x200 while the request for 0x40 is pending:
  - Data for 0x40 is dropped, if_valid=0.
  - The next imem_addr is 0x200 and if_pc=0x200 follows.
- branch_taken coinciding with ack, and branch_taken while in S_HOLD: the held/acked word is discarded and the next request goes to branch_target.
- Async reset asserted mid-S_REQ between edges: outputs clear without a clock edge.
- FETCH_TIMEOUT_EN build with no ack for 64 cycles: imem_fault=1 and remains 1 after a later ack.
